data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-port round-robin arbiter and sequencer for the single-port, byte-addressed data memory. Requester 0 (core load/store stage) and requester 1 (debug/DMA loader) issue word requests over a req/ack handshake. The block serialises them onto the memory's `memRead`/`memWrite`/`address`/`writeData` port and returns registered read data. It rejects misaligned or out-of-range accesses with an error response instead of touching memory.

## Interface
- `DATA_W`, 32: word width; the memory port is fixed at 32.
- `ADDR_W`, 32: requester and memory address width.
- `MEM_BYTES`, 4096: memory size in bytes; addresses with `addr + 3 >= MEM_BYTES` are out of range.

- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0` / `req1` in 1: request valid. Held high with `we`/`addr`/`wdata` stable until `ack`.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in ADDR_W: byte address; must be word-aligned.
- `wdata0` / `wdata1` in DATA_W: write data.
- `ack0` / `ack1` out 1: one-cycle response pulse.
- `err0` / `err1` out 1: valid with `ack`; 1 = rejected (misaligned or out of range).
- `rdata0` / `rdata1` out DATA_W: read data, valid with `ack` for reads.
- `memRead` out 1: memory read enable.
- `memWrite` out 1: memory write enable.
- `address` out ADDR_W: memory address.
- `writeData` out DATA_W: memory write data.
- `readData` in DATA_W: memory read data, combinational from `address`.

## Operation
- FSM states and transitions:
  - IDLE: if any `req` is high, arbitrate and latch the winner's `we`/`addr`/`wdata` and port id, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive the memory. Go to RESP.
  - RESP: pulse the winner's `ack`. Go to IDLE.
- Arbitration is round-robin with a 1-bit `last` register.
  - Only one request pending: it wins.
  - Both pending: the port other than `last` wins.
  - `last` updates to the winner at each grant, including error grants.
- Error check is performed on the latched address in ACCESS: `addr[1:0] != 0` or `addr > MEM_BYTES-4`.
  - On error: `memRead` = `memWrite` = 0; RESP asserts `err` = 1 and `rdata` = 0.
- ACCESS, no error:
  - `address` = latched addr.
  - Read: `memRead` = 1; `readData` is captured into the winner's `rdata` register at the end of the cycle.
  - Write: `memWrite` = 1 and `writeData` = latched wdata; memory commits at the end of ACCESS.
- `memRead`/`memWrite` are high only in ACCESS. `address`/`writeData` are 0 outside ACCESS.
- `rdata0`/`rdata1` hold their value until the next read response on the same port.
- The non-winning port sees no `ack`. Its request stays pending and is served next (starvation-free).

## Timing
- Latency: `req` sampled high at edge N → ACCESS during cycle N+1 → `ack` high during cycle N+2.
  - 3 cycles per transaction; peak throughput is one access per 3 cycles.
- Requester must drop `req` in the cycle after `ack`, or issue a new request. `req` still high in IDLE after RESP is treated as a new request.
- `req` dropped before `ack`: protocol violation. The latched transaction still completes and the `ack` pulse is still issued.
- Reset values: state IDLE, `last` = 1 (port 0 wins first tie), all `ack`/`err` = 0, `rdata0`/`rdata1` = 0, all memory outputs = 0.
- Reset asserted during ACCESS forces `memWrite` low immediately, so the write is not committed. Any pending `ack` is lost.
- Requests arriving in ACCESS/RESP wait; they are sampled in the next IDLE.

## Structure
- Package `data_mem_arb_pkg` contains:
  - state enum `{IDLE, ACCESS, RESP}`
  - `WORD_BYTES` = 4
  - port-id type (1 bit)
- Sub-module `rr_arbiter2`: inputs `req[1:0]` and `last`, outputs one-hot `gnt[1:0]` and `gnt_id`; purely combinational. The `last` register stays in the top.
- Top contains the FSM, latch registers, range/alignment check, and response registers. Target size is about 150-250 lines.

## Test plan
- Single read, port 0: memory word at 1000 = 10; `req0`, `we0` = 0, `addr0` = 1000 → `memRead` high exactly one cycle; `ack0` two cycles after request; `rdata0` = 10, `err0` = 0.
- Write then read, port 1: write 0xDEADBEEF to 1004, then read 1004 → `rdata1` = 0xDEADBEEF. Bytes 1004..1007 = EF, BE, AD, DE.
- Tie: `req0` and `req1` raised together out of reset and held → grant order 0, 1, 0, 1. Each `ack` 3 cycles apart; no port gets two consecutive grants.
- Misaligned/out of range: `addr0` = 1002, then `addr0` = 4094 → `ack0` with `err0` = 1, `memRead`/`memWrite` never asserted, memory unchanged.
- Reset mid-write: assert `rst` during the ACCESS of a write of 0x12345678 to 1008 → all outputs 0 immediately; a later read of 1008 returns the old value 10. The first transaction after reset is arbitrated with port 0 priority.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  typedef logic port_id_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester handshakes and single-port memory bus seen by the arbiter.
interface data_mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              err0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              err1;
  logic [DATA_W-1:0] rdata1;

  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  readData,
    output ack0, err0, rdata0,
    output ack1, err1, rdata1,
    output memRead, memWrite, address, writeData
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output readData,
    input  ack0, err0, rdata0,
    input  ack1, err1, rdata1,
    input  memRead, memWrite, address, writeData
  );
endinterface

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the port other than last.
module rr_arbiter2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last,
  output logic [1:0] gnt,
  output port_id_t   gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        gnt    = last ? 2'b01 : 2'b10;
        gnt_id = ~last;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises two word requesters onto the single-port data memory, one access per
// three cycles, rejecting misaligned or out-of-range addresses without touching memory.
//
// state  | meaning
// IDLE   | arbitrate pending requests, latch the winner
// ACCESS | drive memory with the latched request (or nothing on error)
// RESP   | winner's ack/err/rdata registers are visible for one cycle
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input logic                clk,
  input logic                rst,
  data_mem_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - int'(WORD_BYTES));

  state_e            state_q, state_d;
  port_id_t          last_q, last_d;
  port_id_t          id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic [1:0]        gnt;
  port_id_t          gnt_id;
  logic              acc_err;

  rr_arbiter2 u_arb (
    .req    ({bus.req1, bus.req0}),
    .last   (last_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q > LAST_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          id_d    = gnt_id;
          last_d  = gnt_id;
          we_d    = gnt[1] ? bus.we1    : bus.we0;
          addr_d  = gnt[1] ? bus.addr1  : bus.addr0;
          wdata_d = gnt[1] ? bus.wdata1 : bus.wdata0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (!acc_err) begin
          mem_addr = addr_q;
          if (we_q) begin
            mem_write = 1'b1;
            mem_wdata = wdata_q;
          end else begin
            mem_read = 1'b1;
          end
        end
        ack0_d = (id_q == 1'b0);
        ack1_d = (id_q == 1'b1);
        err0_d = (id_q == 1'b0) && acc_err;
        err1_d = (id_q == 1'b1) && acc_err;
        // An error response reports zero data; writes leave rdata untouched.
        if (acc_err) begin
          if (id_q) rdata1_d = '0;
          else      rdata0_d = '0;
        end else if (!we_q) begin
          if (id_q) rdata1_d = bus.readData;
          else      rdata0_d = bus.readData;
        end
        state_d = RESP;
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.memRead   = mem_read;
  assign bus.memWrite  = mem_write;
  assign bus.address   = mem_addr;
  assign bus.writeData = mem_wdata;

endmodule
